// File: rtl/my_types_pkg.sv
// Shared datapath types: word type and pipeline sequencer state encoding.
`timescale 1ns/1ps
package my_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    DDONE = 2'd2,
    HALT  = 2'd3
  } pipe_state_t;

endpackage

// File: rtl/pipeline_stage_ctrl.sv
// Central pipeline sequencer: drives update/flush of the four pipeline latches
// and the PC enable from cache hits and hazards, buffers a data-cache result
// that arrives while fetch is still stalled, and latches halt.
// Optional: define PIPE_PERF_EN to add the stall_cycles counter output.
`timescale 1ns/1ps
module pipeline_stage_ctrl
  import my_types_pkg::*;
#(
  parameter int unsigned WORD_W = $bits(word_t)
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic              dmem_req,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dload_in,
  input  logic              load_use,
  input  logic              branch_taken,
  input  logic              halt_mem,
  output logic              fd_update,
  output logic              de_update,
  output logic              em_update,
  output logic              mw_update,
  output logic              fd_flush,
  output logic              de_flush,
  output logic              em_flush,
  output logic              mw_flush,
  output logic              pc_en,
  output logic              dmem_mask,
  output logic [WORD_W-1:0] dload_out,
`ifdef PIPE_PERF_EN
  output logic [31:0]       stall_cycles,
`endif
  output logic              halt
);

  pipe_state_t       state_q, state_d;
  logic [WORD_W-1:0] hold_q, hold_d;
  logic              mem_ok;
  logic              adv;

`ifdef PIPE_PERF_EN
  logic [31:0] stall_q, stall_d;
  assign stall_cycles = stall_q;
`endif

  // State, read-data hold register and (optional) stall counter.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= RUN;
      hold_q  <= '0;
`ifdef PIPE_PERF_EN
      stall_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
`ifdef PIPE_PERF_EN
      stall_q <= stall_d;
`endif
    end
  end

  // Advance/stall decision, latch controls and next-state selection.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    mem_ok    = 1'b0;
    adv       = 1'b0;
    fd_update = 1'b0;
    de_update = 1'b0;
    em_update = 1'b0;
    mw_update = 1'b0;
    fd_flush  = 1'b0;
    de_flush  = 1'b0;
    em_flush  = 1'b0;
    mw_flush  = 1'b0;
    pc_en     = 1'b0;

    case (state_q)
      RUN, DWAIT: mem_ok = !dmem_req || dhit;
      DDONE:      mem_ok = 1'b1;
      default:    mem_ok = 1'b0;
    endcase
    adv = ihit && mem_ok && (state_q != HALT);

    if (state_q != HALT) begin
      if (adv) begin
        pc_en     = 1'b1;
        fd_update = 1'b1;
        de_update = 1'b1;
        em_update = 1'b1;
        mw_update = 1'b1;
        if (branch_taken) begin
          fd_flush = 1'b1;
          de_flush = 1'b1;
          em_flush = 1'b1;
        end else if (load_use) begin
          // Hold PC and fetch/decode; decode/execute takes a bubble.
          pc_en     = 1'b0;
          fd_update = 1'b0;
          de_flush  = 1'b1;
        end
      end else if (state_q != DDONE && dhit && !ihit) begin
        // Data result is being buffered: leave the mw latch untouched.
        mw_update = 1'b0;
        mw_flush  = 1'b0;
      end else begin
        mw_update = 1'b1;
        mw_flush  = 1'b1;
      end

      if (halt_mem && adv) begin
        state_d = HALT;
      end else begin
        case (state_q)
          RUN, DWAIT: begin
            if (dhit && !ihit) begin
              state_d = DDONE;
              hold_d  = dload_in;
            end else if (dhit) begin
              state_d = RUN;
            end else if (state_q == DWAIT || dmem_req) begin
              state_d = DWAIT;
            end else begin
              state_d = RUN;
            end
          end
          DDONE:   state_d = ihit ? RUN : DDONE;
          default: state_d = state_q;
        endcase
      end
    end

    dmem_mask = (state_q == DDONE) || (state_q == HALT);
    dload_out = (state_q == DDONE) ? hold_q : dload_in;
    halt      = (state_q == HALT);
  end

`ifdef PIPE_PERF_EN
  // Stall cycle count, frozen once halted.
  always_comb begin
    stall_d = stall_q;
    if (state_q != HALT && !adv) stall_d = stall_q + 32'd1;
  end
`endif

endmodule

// File: tb/tb_pipeline_stage_ctrl.sv
// Self-checking bench for pipeline_stage_ctrl: a reference model pushes the
// expected outputs for each cycle into a scoreboard, popped at the falling edge.
`timescale 1ns/1ps
module tb_pipeline_stage_ctrl;

  localparam int M_RUN = 0, M_DWAIT = 1, M_DDONE = 2, M_HALT = 3;

  typedef struct packed {
    logic [3:0]  upd;   // {fd, de, em, mw}
    logic [3:0]  fl;    // {fd, de, em, mw}
    logic        pc;
    logic        mask;
    logic        hlt;
    logic [31:0] dout;
    logic [31:0] stall;
  } exp_t;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        ihit = 1'b0, dmem_req = 1'b0, dhit = 1'b0;
  logic [31:0] dload_in = '0;
  logic        load_use = 1'b0, branch_taken = 1'b0, halt_mem = 1'b0;
  logic        fd_update, de_update, em_update, mw_update;
  logic        fd_flush, de_flush, em_flush, mw_flush;
  logic        pc_en, dmem_mask, halt;
  logic [31:0] dload_out;
`ifdef PIPE_PERF_EN
  logic [31:0] stall_cycles;
`endif

  int   n_total = 0;
  int   n_bad   = 0;
  exp_t sb[$];

  int          mdl_st, nx_st;
  logic [31:0] mdl_hold, nx_hold;
  logic [31:0] mdl_stall, nx_stall;

  pipeline_stage_ctrl #(.WORD_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dmem_req(dmem_req), .dhit(dhit),
    .dload_in(dload_in), .load_use(load_use), .branch_taken(branch_taken),
    .halt_mem(halt_mem),
    .fd_update(fd_update), .de_update(de_update), .em_update(em_update),
    .mw_update(mw_update), .fd_flush(fd_flush), .de_flush(de_flush),
    .em_flush(em_flush), .mw_flush(mw_flush), .pc_en(pc_en),
    .dmem_mask(dmem_mask), .dload_out(dload_out),
`ifdef PIPE_PERF_EN
    .stall_cycles(stall_cycles),
`endif
    .halt(halt)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: expected outputs from the current model state, plus next state.
  task automatic model(input logic ih, dr, dh, input logic [31:0] din,
                       input logic lu, bt, hm, output exp_t e);
    logic ok, a;
    ok = (mdl_st == M_DDONE) ? 1'b1 : (!dr || dh);
    a  = (mdl_st != M_HALT) && ih && ok;
    e.upd = 4'b0000; e.fl = 4'b0000; e.pc = 1'b0;
    e.mask  = (mdl_st == M_DDONE) || (mdl_st == M_HALT);
    e.hlt   = (mdl_st == M_HALT);
    e.dout  = (mdl_st == M_DDONE) ? mdl_hold : din;
    e.stall = mdl_stall;
    nx_st = mdl_st; nx_hold = mdl_hold; nx_stall = mdl_stall;
    if (mdl_st != M_HALT) begin
      if (a) begin
        e.upd = 4'b1111; e.pc = 1'b1;
        if (bt) e.fl = 4'b1110;
        else if (lu) begin e.pc = 1'b0; e.upd = 4'b0111; e.fl = 4'b0100; end
      end else begin
        nx_stall = mdl_stall + 32'd1;
        if (mdl_st != M_DDONE && dh && !ih) begin e.upd = 4'b0000; e.fl = 4'b0000; end
        else begin e.upd = 4'b0001; e.fl = 4'b0001; end
      end
      if (hm && a) nx_st = M_HALT;
      else if (mdl_st == M_DDONE) nx_st = ih ? M_RUN : M_DDONE;
      else if (dh && !ih) begin nx_st = M_DDONE; nx_hold = din; end
      else if (dh) nx_st = M_RUN;
      else if (mdl_st == M_DWAIT) nx_st = M_DWAIT;
      else nx_st = dr ? M_DWAIT : M_RUN;
    end
  endtask

  task automatic commit();
    mdl_st = nx_st; mdl_hold = nx_hold; mdl_stall = nx_stall;
  endtask

  task automatic compare_pop(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_total++; n_bad++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      check_val({tag, ".upd"},  {60'd0, fd_update, de_update, em_update, mw_update}, {60'd0, e.upd});
      check_val({tag, ".flush"}, {60'd0, fd_flush, de_flush, em_flush, mw_flush}, {60'd0, e.fl});
      check_val({tag, ".pc_en"}, {63'd0, pc_en}, {63'd0, e.pc});
      check_val({tag, ".mask"},  {63'd0, dmem_mask}, {63'd0, e.mask});
      check_val({tag, ".halt"},  {63'd0, halt}, {63'd0, e.hlt});
      check_val({tag, ".dout"},  {32'd0, dload_out}, {32'd0, e.dout});
`ifdef PIPE_PERF_EN
      check_val({tag, ".stall"}, {32'd0, stall_cycles}, {32'd0, e.stall});
`endif
    end
  endtask

  // One clock cycle: drive inputs just after the rising edge, check at the falling edge.
  task automatic cyc(input string tag, input logic ih, dr, dh, input logic [31:0] din,
                     input logic lu, bt, hm);
    exp_t e;
    ihit = ih; dmem_req = dr; dhit = dh; dload_in = din;
    load_use = lu; branch_taken = bt; halt_mem = hm;
    model(ih, dr, dh, din, lu, bt, hm, e);
    sb.push_back(e);
    @(negedge CLK);
    compare_pop(tag);
    @(posedge CLK);
    #1;
    commit();
  endtask

  // Asynchronous reset mid-cycle; the release edge sees all inputs low.
  task automatic do_reset(input string tag);
    exp_t e;
    ihit = 0; dmem_req = 0; dhit = 0; dload_in = 32'h0BAD_F00D;
    load_use = 0; branch_taken = 0; halt_mem = 0;
    nRST = 1'b0;
    mdl_st = M_RUN; mdl_hold = '0; mdl_stall = '0;
    model(1'b0, 1'b0, 1'b0, 32'h0BAD_F00D, 1'b0, 1'b0, 1'b0, e);
    sb.push_back(e);
    #2;
    compare_pop(tag);
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;
    commit();
  endtask

  initial begin
    @(posedge CLK);
    #1;
    do_reset("reset0");

    cyc("adv0", 1, 0, 0, 32'h1, 0, 0, 0);
    cyc("adv1", 1, 0, 0, 32'h2, 0, 0, 0);

    for (int i = 0; i < 3; i++) cyc("dwait", 1, 1, 0, 32'h10 + i, 0, 0, 0);
    cyc("dwait_done", 1, 1, 1, 32'h55, 0, 0, 0);
    cyc("after_dwait", 1, 0, 0, 32'h56, 0, 0, 0);

    cyc("ddone_in", 0, 1, 1, 32'hDEADBEEF, 0, 0, 0);
    cyc("ddone_a", 0, 1, 0, 32'h12345678, 0, 0, 0);
    cyc("ddone_b", 0, 0, 0, 32'hAAAA5555, 0, 0, 0);
    cyc("ddone_adv", 1, 1, 0, 32'h0, 0, 0, 0);
    cyc("ddone_run", 1, 0, 0, 32'h77, 0, 0, 0);

    cyc("same_cyc", 1, 1, 1, 32'h99, 0, 0, 0);
    cyc("same_next", 1, 0, 0, 32'h9A, 0, 0, 0);

    cyc("br_lu", 1, 0, 0, 32'h3, 1, 1, 0);
    cyc("lu", 1, 0, 0, 32'h4, 1, 0, 0);
    cyc("lu_stall", 0, 0, 0, 32'h5, 1, 0, 0);
    cyc("br_stall", 0, 1, 0, 32'h6, 0, 1, 0);

    cyc("rst_dw_a", 0, 1, 0, 32'h7, 0, 0, 0);
    cyc("rst_dw_b", 0, 1, 0, 32'h8, 0, 0, 0);
    do_reset("reset_dwait");
    cyc("post_rst_dw", 1, 0, 0, 32'h9, 0, 0, 0);

    cyc("rst_dd_a", 0, 1, 1, 32'hCAFEF00D, 0, 0, 0);
    cyc("rst_dd_b", 0, 0, 0, 32'h1111, 0, 0, 0);
    do_reset("reset_ddone");
    cyc("post_rst_dd", 0, 0, 0, 32'h2222, 0, 0, 0);

    for (int i = 0; i < 80; i++) begin
      cyc("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 2) == 0), $urandom, 1'($urandom_range(0, 3) == 0),
          1'($urandom_range(0, 4) == 0), 1'b0);
    end
    cyc("pre_halt", 1, 0, 0, 32'h40, 0, 0, 0);

    cyc("halt_in", 1, 0, 0, 32'h41, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      cyc("halted", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    do_reset("reset_halt");
    cyc("post_halt", 1, 0, 0, 32'h50, 0, 0, 0);

    cyc("ddone_halt_a", 0, 1, 1, 32'hFEEDFACE, 0, 0, 0);
    cyc("ddone_halt_b", 1, 0, 0, 32'h60, 0, 0, 1);
    cyc("ddone_halted", 1, 0, 0, 32'h61, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
